// File: rtl/isax_top.sv
// -----------------------------------------------------------------------------
// isax_top
// Custom-instruction (ISAX) functional unit behind a RoCC-style
// command/response stream. Each input beat carries one packed RoCC command
// (instruction word plus the two source register values). The 64-bit integer
// operation selected by funct7 is evaluated combinationally. The result is
// captured in a single-entry output register and returned as one 128-bit
// response beat that carries the destination register index rd.
//
// Ports
//   ap_clk        in   1    single clock, rising edge
//   ap_rst        in   1    asynchronous active-high reset, released synchronously
//   ap_start      in   1    input enable; while low no new command is accepted
//   ap_done       out  1    pulse on every response-beat handshake
//   ap_idle       out  1    high when no result is held
//   ap_ready      out  1    pulse on every command-beat handshake
//   IN_r_TVALID   in   1    command beat valid
//   IN_r_TREADY   out  1    command beat ready
//   IN_r_TDATA    in   192  [31:0] inst, [63:32] reserved, [127:64] rs1, [191:128] rs2
//   OUT_r_TVALID  out  1    response beat valid
//   OUT_r_TREADY  in   1    response beat ready
//   OUT_r_TDATA   out  128  [4:0] rd, [63:5] zero, [127:64] result
// -----------------------------------------------------------------------------
module isax_top #(
  parameter int XLEN  = 64,
  parameter int IN_W  = 2 * XLEN + 64,
  parameter int OUT_W = 2 * XLEN
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic             IN_r_TVALID,
  output logic             IN_r_TREADY,
  input  logic [IN_W-1:0]  IN_r_TDATA,
  output logic             OUT_r_TVALID,
  input  logic             OUT_r_TREADY,
  output logic [OUT_W-1:0] OUT_r_TDATA
);

  // ---------------------------------------------------------------------------
  // funct7 operation codes
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OP_ADD    = 7'd0;
  localparam logic [6:0] OP_SUB    = 7'd1;
  localparam logic [6:0] OP_AND    = 7'd2;
  localparam logic [6:0] OP_OR     = 7'd3;
  localparam logic [6:0] OP_XOR    = 7'd4;
  localparam logic [6:0] OP_SLL    = 7'd5;
  localparam logic [6:0] OP_SRL    = 7'd6;
  localparam logic [6:0] OP_SRA    = 7'd7;
  localparam logic [6:0] OP_SLT    = 7'd8;
  localparam logic [6:0] OP_SLTU   = 7'd9;
  localparam logic [6:0] OP_MIN    = 7'd10;
  localparam logic [6:0] OP_MAX    = 7'd11;
  localparam logic [6:0] OP_POPCNT = 7'd12;
  localparam logic [6:0] OP_CLZ    = 7'd13;
  localparam logic [6:0] OP_MUL    = 7'd14;

  // ---------------------------------------------------------------------------
  // Bit-counting helpers
  // ---------------------------------------------------------------------------

  // Number of set bits in a 64-bit word (0..64 fits in 7 bits).
  function automatic logic [6:0] f_popcnt(input logic [XLEN-1:0] v);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < XLEN; i++) begin
      cnt = cnt + {6'd0, v[i]};
    end
    return cnt;
  endfunction

  // Leading-zero count scanning from the MSB; an all-zero word yields 64.
  function automatic logic [6:0] f_clz(input logic [XLEN-1:0] v);
    logic [6:0] cnt;
    logic       found;
    cnt   = 7'd0;
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found && (v[i] == 1'b0)) begin
        cnt = cnt + 7'd1;
      end else begin
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [31:0]     w_inst;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [6:0]      w_funct7;
  logic            w_xs1;
  logic            w_xs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [5:0]      w_shamt;

  assign w_inst   = IN_r_TDATA[31:0];
  assign w_rs1    = IN_r_TDATA[64 +: XLEN];
  assign w_rs2    = IN_r_TDATA[64 + XLEN +: XLEN];
  assign w_funct7 = w_inst[31:25];
  assign w_xs1    = w_inst[13];
  assign w_xs2    = w_inst[12];
  assign w_rd     = w_inst[11:7];

  // A source that is not marked as read contributes zero, not the bus value.
  assign w_a      = w_xs1 ? w_rs1 : {XLEN{1'b0}};
  assign w_b      = w_xs2 ? w_rs2 : {XLEN{1'b0}};
  assign w_shamt  = w_b[5:0];

  // Register indices, xd, opcode and the reserved word carry no meaning here;
  // they are folded into one deliberately unused net.
  logic w_unused_fields;
  assign w_unused_fields = ^{IN_r_TDATA[63:32], w_inst[24:14], w_inst[6:0]};

  // ---------------------------------------------------------------------------
  // Operation results
  // ---------------------------------------------------------------------------
  logic            w_lt_signed;
  logic            w_lt_unsigned;
  logic [XLEN-1:0] w_sra;
  logic [XLEN-1:0] w_mul;
  logic [XLEN-1:0] w_result;

  assign w_lt_signed   = ($signed(w_a) < $signed(w_b));
  assign w_lt_unsigned = (w_a < w_b);
  assign w_sra         = XLEN'($signed(w_a) >>> w_shamt);
  // Only the low half of the product is returned; the multiply wraps mod 2^64.
  assign w_mul         = XLEN'(w_a * w_b);

  // Result selection by funct7; unknown encodings return zero.
  always_comb begin
    w_result = {XLEN{1'b0}};
    case (w_funct7)
      OP_ADD:    w_result = w_a + w_b;
      OP_SUB:    w_result = w_a - w_b;
      OP_AND:    w_result = w_a & w_b;
      OP_OR:     w_result = w_a | w_b;
      OP_XOR:    w_result = w_a ^ w_b;
      OP_SLL:    w_result = w_a << w_shamt;
      OP_SRL:    w_result = w_a >> w_shamt;
      OP_SRA:    w_result = w_sra;
      OP_SLT:    w_result = {{(XLEN-1){1'b0}}, w_lt_signed};
      OP_SLTU:   w_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
      OP_MIN:    w_result = w_lt_signed ? w_a : w_b;
      OP_MAX:    w_result = w_lt_signed ? w_b : w_a;
      OP_POPCNT: w_result = {{(XLEN-7){1'b0}}, f_popcnt(w_a)};
      OP_CLZ:    w_result = {{(XLEN-7){1'b0}}, f_clz(w_a)};
      OP_MUL:    w_result = w_mul;
      default:   w_result = {XLEN{1'b0}};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-entry output register and handshakes
  // ---------------------------------------------------------------------------
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             w_in_ready;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [OUT_W-1:0] w_rsp;

  // A new command may enter when the slot is empty or is being emptied in the
  // same cycle, which gives full 1 beat/cycle throughput with one register.
  assign w_in_ready = !ap_rst && ap_start && (!r_out_valid || OUT_r_TREADY);
  assign w_in_hs    = IN_r_TVALID && w_in_ready;
  assign w_out_hs   = r_out_valid && OUT_r_TREADY;
  assign w_rsp      = {w_result, {(XLEN-5){1'b0}}, w_rd};

  // Response slot: load on accept (takes priority over drain), clear on drain.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {OUT_W{1'b0}};
    end else if (w_in_hs) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_rsp;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
    end
  end

  assign IN_r_TREADY  = w_in_ready;
  assign OUT_r_TVALID = r_out_valid;
  assign OUT_r_TDATA  = r_out_data;
  assign ap_ready     = w_in_hs;
  assign ap_done      = w_out_hs;
  assign ap_idle      = !r_out_valid;

endmodule

// File: tb/tb_isax_top.sv
// -----------------------------------------------------------------------------
// tb_isax_top
// Self-checking bench for isax_top: a table of directed operation vectors,
// then hand-written backpressure, streaming, ap_start and reset sequences.
// Expected responses are queued on each command handshake and compared when
// the matching response handshake occurs.
// -----------------------------------------------------------------------------
module tb_isax_top;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic         ap_start;
  logic         ap_done;
  logic         ap_idle;
  logic         ap_ready;
  logic         IN_r_TVALID;
  logic         IN_r_TREADY;
  logic [191:0] IN_r_TDATA;
  logic         OUT_r_TVALID;
  logic         OUT_r_TREADY;
  logic [127:0] OUT_r_TDATA;

  isax_top dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .IN_r_TVALID  (IN_r_TVALID),
    .IN_r_TREADY  (IN_r_TREADY),
    .IN_r_TDATA   (IN_r_TDATA),
    .OUT_r_TVALID (OUT_r_TVALID),
    .OUT_r_TREADY (OUT_r_TREADY),
    .OUT_r_TDATA  (OUT_r_TDATA)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    string       name;
    logic [6:0]  f7;
    logic        xd;
    logic        xs1;
    logic        xs2;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
  } vec_t;

  vec_t         vecs[20];
  logic [127:0] sb[$];
  logic [127:0] cur_exp;
  logic [127:0] exp_a;
  int           err_cnt  = 0;
  int           chk_cnt  = 0;
  int           rdy_cnt  = 0;
  int           done_cnt = 0;

  function automatic logic [191:0] mk_cmd(input logic [6:0] f7, input logic xd,
                                          input logic xs1, input logic xs2,
                                          input logic [4:0] rd,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] inst;
    inst = {f7, 5'd2, 5'd1, xd, xs1, xs2, rd, 7'h0B};
    return {b, a, 32'h0, inst};
  endfunction

  function automatic logic [127:0] mk_rsp(input logic [4:0] rd, input logic [63:0] res);
    return {res, 59'd0, rd};
  endfunction

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Sampled on the falling edge: record accepted commands, check responses.
  task automatic mon();
    logic [127:0] e;
    if (ap_ready) rdy_cnt++;
    if (ap_done) done_cnt++;
    if (OUT_r_TVALID && OUT_r_TREADY) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL unexpected_resp: got %h expected no response", OUT_r_TDATA);
      end else begin
        e = sb.pop_front();
        check("resp", OUT_r_TDATA, e);
      end
    end
    if (IN_r_TVALID && IN_r_TREADY) sb.push_back(cur_exp);
  endtask

  task automatic step();
    @(negedge ap_clk);
    mon();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send(input logic [6:0] f7, input logic xd, input logic xs1,
                      input logic xs2, input logic [4:0] rd,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] res);
    IN_r_TVALID = 1'b1;
    IN_r_TDATA  = mk_cmd(f7, xd, xs1, xs2, rd, a, b);
    cur_exp     = mk_rsp(rd, res);
  endtask

  task automatic drain(input string nm);
    IN_r_TVALID = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) step();
    check(nm, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"add",     7'd0,   1'b1, 1'b1, 1'b1, 5'd5,  64'd3, 64'd4, 64'd7};
    vecs[1]  = '{"sub_gate",7'd1,   1'b1, 1'b1, 1'b0, 5'd1,  64'd10, 64'd99, 64'd10};
    vecs[2]  = '{"sub_wrap",7'd1,   1'b1, 1'b1, 1'b1, 5'd2,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3]  = '{"sra",     7'd7,   1'b1, 1'b1, 1'b1, 5'd3,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
    vecs[4]  = '{"clz0",    7'd13,  1'b1, 1'b1, 1'b0, 5'd4,  64'd0, 64'd0, 64'd64};
    vecs[5]  = '{"popcnt",  7'd12,  1'b1, 1'b1, 1'b0, 5'd6,  64'hFF, 64'd0, 64'd8};
    vecs[6]  = '{"mul_wrap",7'd14,  1'b1, 1'b1, 1'b1, 5'd7,  64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
    vecs[7]  = '{"bad_op",  7'd100, 1'b1, 1'b1, 1'b1, 5'd8,  64'd5, 64'd6, 64'd0};
    vecs[8]  = '{"and",     7'd2,   1'b1, 1'b1, 1'b1, 5'd9,  64'hF0F0, 64'hFF00, 64'hF000};
    vecs[9]  = '{"or",      7'd3,   1'b0, 1'b1, 1'b1, 5'd10, 64'hF0F0, 64'hFF00, 64'hFFF0};
    vecs[10] = '{"xor",     7'd4,   1'b1, 1'b1, 1'b1, 5'd11, 64'hF0F0, 64'hFF00, 64'h0FF0};
    vecs[11] = '{"sll",     7'd5,   1'b1, 1'b1, 1'b1, 5'd12, 64'd1, 64'd65, 64'd2};
    vecs[12] = '{"srl",     7'd6,   1'b1, 1'b1, 1'b1, 5'd13, 64'h8000_0000_0000_0000, 64'd63, 64'd1};
    vecs[13] = '{"slt",     7'd8,   1'b1, 1'b1, 1'b1, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
    vecs[14] = '{"sltu",    7'd9,   1'b1, 1'b1, 1'b1, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    vecs[15] = '{"min",     7'd10,  1'b1, 1'b1, 1'b1, 5'd16, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB};
    vecs[16] = '{"max",     7'd11,  1'b1, 1'b1, 1'b1, 5'd17, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd3};
    vecs[17] = '{"clz1",    7'd13,  1'b1, 1'b1, 1'b0, 5'd18, 64'd1, 64'd0, 64'd63};
    vecs[18] = '{"add_xs1", 7'd0,   1'b1, 1'b0, 1'b1, 5'd19, 64'd7, 64'd8, 64'd8};
    vecs[19] = '{"mul",     7'd14,  1'b0, 1'b1, 1'b1, 5'd31, 64'd3, 64'd5, 64'd15};

    // ---- reset state ----
    ap_rst       = 1'b1;
    ap_start     = 1'b1;
    OUT_r_TREADY = 1'b1;
    send(7'd0, 1'b1, 1'b1, 1'b1, 5'd1, 64'd1, 64'd1, 64'd2);
    step();
    step();
    #1;
    check("rst_tvalid", 128'(OUT_r_TVALID), 128'd0);
    check("rst_tdata",  OUT_r_TDATA, 128'd0);
    check("rst_idle",   128'(ap_idle), 128'd1);
    check("rst_tready", 128'(IN_r_TREADY), 128'd0);
    check("rst_ready",  128'(ap_ready), 128'd0);
    check("rst_done",   128'(ap_done), 128'd0);
    IN_r_TVALID = 1'b0;
    ap_rst      = 1'b0;
    step();

    // ---- operation table ----
    for (int i = 0; i < 20; i++) begin
      send(vecs[i].f7, vecs[i].xd, vecs[i].xs1, vecs[i].xs2, vecs[i].rd,
           vecs[i].a, vecs[i].b, vecs[i].res);
      step();
      if (i == 0) check("latency_valid", 128'(OUT_r_TVALID), 128'd1);
      IN_r_TVALID = 1'b0;
      step();
      if (i == 0) check("idle_after", 128'(ap_idle), 128'd1);
    end

    // ---- backpressure ----
    OUT_r_TREADY = 1'b0;
    exp_a = mk_rsp(5'd3, 64'd2);
    send(7'd0, 1'b1, 1'b1, 1'b1, 5'd3, 64'd1, 64'd1, 64'd2);
    step();
    send(7'd1, 1'b1, 1'b1, 1'b1, 5'd4, 64'd50, 64'd8, 64'd42);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid",  128'(OUT_r_TVALID), 128'd1);
      check("bp_data",   OUT_r_TDATA, exp_a);
      check("bp_tready", 128'(IN_r_TREADY), 128'd0);
      step();
    end
    OUT_r_TREADY = 1'b1;
    step();
    send(7'd4, 1'b1, 1'b1, 1'b1, 5'd9, 64'hAA, 64'h0F, 64'hA5);
    step();
    drain("bp_drain");

    // ---- streaming 16 back-to-back ----
    rdy_cnt  = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      send(7'd0, 1'b1, 1'b1, 1'b1, 5'(i), 64'(i * 3), 64'd100, 64'(i * 3 + 100));
      #1;
      check("stream_tready", 128'(IN_r_TREADY), 128'd1);
      step();
    end
    check("stream_inflight", 128'(sb.size()), 128'd1);
    drain("stream_drain");
    check("stream_ready_cnt", 128'(rdy_cnt), 128'd16);
    check("stream_done_cnt",  128'(done_cnt), 128'd16);

    // ---- ap_start low blocks input, held result drains ----
    OUT_r_TREADY = 1'b0;
    send(7'd2, 1'b1, 1'b1, 1'b1, 5'd21, 64'hFF, 64'h3C, 64'h3C);
    step();
    ap_start = 1'b0;
    send(7'd0, 1'b1, 1'b1, 1'b1, 5'd22, 64'd1, 64'd2, 64'd3);
    OUT_r_TREADY = 1'b1;
    #1;
    check("start_tready", 128'(IN_r_TREADY), 128'd0);
    step();
    check("start_drained", 128'(OUT_r_TVALID), 128'd0);
    check("start_idle",    128'(ap_idle), 128'd1);
    step();
    check("start_no_accept", 128'(sb.size()), 128'd0);
    IN_r_TVALID = 1'b0;
    ap_start    = 1'b1;

    // ---- reset while a result is held ----
    OUT_r_TREADY = 1'b0;
    send(7'd0, 1'b1, 1'b1, 1'b1, 5'd23, 64'd40, 64'd2, 64'd42);
    step();
    IN_r_TVALID = 1'b0;
    check("mid_valid", 128'(OUT_r_TVALID), 128'd1);
    ap_rst = 1'b1;
    #1;
    check("mid_rst_valid",  128'(OUT_r_TVALID), 128'd0);
    check("mid_rst_idle",   128'(ap_idle), 128'd1);
    check("mid_rst_data",   OUT_r_TDATA, 128'd0);
    check("mid_rst_tready", 128'(IN_r_TREADY), 128'd0);
    sb.delete();
    step();
    step();
    ap_rst       = 1'b0;
    OUT_r_TREADY = 1'b1;
    repeat (3) step();
    check("post_rst_valid", 128'(OUT_r_TVALID), 128'd0);

    // ---- recovery after reset ----
    send(7'd14, 1'b1, 1'b1, 1'b1, 5'd24, 64'd6, 64'd7, 64'd42);
    step();
    drain("recover_drain");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
